// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart_tx arbiter: FSM encoding, debug view,
// default start timeout and the requester-index width helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_START_TIMEOUT = 16;
  localparam int MAX_ID_W          = 3;

  typedef struct packed {
    state_t                state;
    logic [MAX_ID_W-1:0]   ptr;
    logic                  last_q;
  } dbg_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx start/busy link and arbiter status.
// Transfer rule: a byte moves when req_valid[i] & req_ready[i] are both high at a rising edge.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic [ID_W-1:0]    grant_id;
  logic               active;
  logic               err_timeout;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, active, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, active, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or after ptr, wrapping modulo N_REQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_found,
  output logic [ID_W-1:0]  o_idx
);

  int              w_j;
  logic [ID_W-1:0] w_j_idx;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_j     = 0;
    w_j_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_j     = (int'(i_ptr) + k) % N_REQ;
      w_j_idx = ID_W'(w_j);
      if (i_req[w_j_idx]) begin
        o_found = 1'b1;
        o_idx   = w_j_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte streams: round-robin choice, frame lock
// until the last byte, start/busy sequencing and a start-acknowledge timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic             clk_25mhz,
  input  logic             resetn,
  uart_tx_arbiter_if.slave bus,
  output dbg_t             o_dbg
);

  localparam int               ID_W     = id_w(N_REQ);
  localparam int               CNT_W    = $clog2(START_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_ptr;
  logic             r_last_q;
  logic [7:0]       r_tx_data;
  logic [ID_W-1:0]  r_grant_id;
  logic             r_active;
  logic             r_err;

  logic             w_rr_found;
  logic [ID_W-1:0]  w_rr_idx;
  logic             w_cand_found;
  logic [ID_W-1:0]  w_cand_idx;
  logic             w_accept;
  logic             w_timeout;
  logic [ID_W-1:0]  w_ptr_next;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  // A held lock pins the candidate even while its owner has nothing to send.
  always_comb begin
    w_cand_found = w_rr_found;
    w_cand_idx   = w_rr_idx;
    if (r_active) begin
      w_cand_found = bus.req_valid[r_grant_id];
      w_cand_idx   = r_grant_id;
    end
  end

  assign w_accept   = (r_state == ST_IDLE) && w_cand_found && resetn;
  assign w_timeout  = (r_state == ST_START) && !bus.tx_busy && (r_cnt == CNT_LAST);
  assign w_ptr_next = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next_state = w_cand_found ? ST_START : ST_IDLE;
      ST_START: begin
        if (bus.tx_busy)    w_next_state = ST_DRAIN;
        else if (w_timeout) w_next_state = ST_IDLE;
        else                w_next_state = ST_START;
      end
      ST_DRAIN: w_next_state = bus.tx_busy ? ST_DRAIN : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.tx_start  = 1'b0;
    if (w_accept) bus.req_ready[w_cand_idx] = 1'b1;
    if (r_state == ST_START) bus.tx_start = 1'b1;
  end

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_last_q   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant_id <= '0;
      r_active   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_timeout;
      case (r_state)
        ST_IDLE: begin
          if (w_cand_found) begin
            r_tx_data  <= bus.req_data[8*w_cand_idx +: 8];
            r_last_q   <= bus.req_last[w_cand_idx];
            r_grant_id <= w_cand_idx;
            r_active   <= 1'b1;
            r_cnt      <= '0;
          end
        end
        ST_START: begin
          if (bus.tx_busy) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_ptr    <= w_ptr_next;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!bus.tx_busy && r_last_q) begin
            r_active <= 1'b0;
            r_ptr    <= w_ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_data     = r_tx_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.active      = r_active;
  assign bus.err_timeout = r_err;

  assign o_dbg.state  = r_state;
  assign o_dbg.ptr    = MAX_ID_W'(r_ptr);
  assign o_dbg.last_q = r_last_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: requester queues, a busy-stretching
// uart_tx model, and a monitor that checks each byte handed to the serializer.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int W        = ID_W + 8;
  localparam int BUSY_LEN = 10;

  // ---------------- clock / reset ----------------
  logic clk_25mhz = 1'b0;
  logic resetn    = 1'b0;
  int   cyc       = 0;
  dbg_t dbg;

  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(16)) dut (
    .clk_25mhz (clk_25mhz),
    .resetn    (resetn),
    .bus       (bus),
    .o_dbg     (dbg)
  );

  // ---------------- bookkeeping ----------------
  int            n_vec  = 0;
  int            n_miss = 0;
  logic [W-1:0]  exp_q[$];
  logic [16:0]   src_q[N][$];   // {gap[7:0], last, data}
  int            acc_cnt[N];
  logic [N-1:0]  acc_mask = '0;
  int            acc_cyc  = -100;
  int            err_cnt  = 0;
  int            rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // ---------------- uart_tx model ----------------
  logic model_busy = 1'b0;
  logic model_en   = 1'b1;
  int   busy_cnt   = 0;
  assign bus.tx_busy = model_busy;

  always @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      busy_cnt   <= 0;
      model_busy <= 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt   <= busy_cnt - 1;
      model_busy <= (busy_cnt > 1);
    end else if (bus.tx_start && model_en) begin
      busy_cnt   <= BUSY_LEN;
      model_busy <= 1'b1;
    end
  end

  // ---------------- requester driver ----------------
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk_25mhz);
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          acc_cnt[i]++;
        end
      end
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = 1'b0;
        if (src_q[i].size() > 0) begin
          if (src_q[i][0][16:9] == 8'd0) begin
            bus.req_valid[i]        = 1'b1;
            bus.req_last[i]         = src_q[i][0][8];
            bus.req_data[8*i +: 8]  = src_q[i][0][7:0];
          end else begin
            src_q[i][0] = src_q[i][0] - 17'h200;
          end
        end
      end
      #1;
      acc_mask = bus.req_valid & bus.req_ready;
      if (bus.req_ready != '0) begin
        acc_cyc = cyc;
        check("ready_onehot", $countones(bus.req_ready), 1);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         prev_start;
    logic         prev_busy;
    logic [W-1:0] e;
    prev_start = 1'b0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge clk_25mhz);
      #2;
      if (bus.tx_start && !prev_start) begin
        rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_byte: got id %0d data 0x%0h with nothing expected", bus.grant_id, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("byte", {bus.grant_id, bus.tx_data}, e);
          check("start_latency", cyc - acc_cyc, 1);
        end
      end
      if (prev_start && prev_busy) check("start_drop_after_busy", bus.tx_start, 0);
      if (bus.err_timeout) begin
        err_cnt++;
        check("timeout_latency", cyc - rise_cyc, 16);
        check("timeout_unlock", {bus.active, bus.tx_start}, 0);
      end
      prev_start = bus.tx_start;
      prev_busy  = bus.tx_busy;
    end
  end

  // ---------------- helpers ----------------
  task automatic push_src(input int r, input logic [7:0] d, input logic last, input int gap);
    logic [7:0] g;
    g = 8'(gap);
    src_q[r].push_back({g, last, d});
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    logic [ID_W-1:0] id;
    id = ID_W'(r);
    exp_q.push_back({id, d});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while (t < budget && !(exp_q.size() == 0 && srcs_empty() &&
                           dbg.state == ST_IDLE && !bus.tx_busy)) begin
      @(negedge clk_25mhz);
      #3;
      t++;
    end
    if (t >= budget) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: traffic did not drain within %0d cycles, %0d bytes still expected", name, budget, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_start"},  bus.tx_start, 0);
    check({name, "_tx_data"},   bus.tx_data, 0);
    check({name, "_req_ready"}, bus.req_ready, 0);
    check({name, "_grant_act"}, {bus.grant_id, bus.active, bus.err_timeout}, 0);
    check({name, "_dbg"},       dbg, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_25mhz);
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk_25mhz);
    resetn = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int base[N];
    int t;

    repeat (3) @(negedge clk_25mhz);
    #1;
    check_reset_outputs("por");
    resetn = 1'b1;

    // Test 1: single byte from requester 1
    @(posedge clk_25mhz);
    for (int i = 0; i < N; i++) base[i] = acc_cnt[i];
    push_src(1, 8'h41, 1'b1, 0);
    expect_byte(1, 8'h41);
    wait_drain("basic", 200);
    check("t1_accepts_r1", acc_cnt[1] - base[1], 1);
    check("t1_grant_active", {bus.grant_id, bus.active}, {2'd1, 1'b0});
    check("t1_ptr", dbg.ptr, 2);

    // Test 2: round robin from a fresh reset
    do_reset();
    @(posedge clk_25mhz);
    for (int i = 0; i < N; i++) base[i] = acc_cnt[i];
    push_src(0, 8'h00, 1'b1, 0); push_src(0, 8'h04, 1'b1, 0);
    push_src(1, 8'h01, 1'b1, 0); push_src(1, 8'h05, 1'b1, 0);
    push_src(2, 8'h02, 1'b1, 0);
    push_src(3, 8'h03, 1'b1, 0);
    expect_byte(0, 8'h00); expect_byte(1, 8'h01);
    expect_byte(2, 8'h02); expect_byte(3, 8'h03);
    expect_byte(0, 8'h04); expect_byte(1, 8'h05);
    wait_drain("round_robin", 400);
    check("t2_accepts", {8'(acc_cnt[0] - base[0]), 8'(acc_cnt[1] - base[1]),
                         8'(acc_cnt[2] - base[2]), 8'(acc_cnt[3] - base[3])}, 32'h02020101);
    check("t2_ptr", dbg.ptr, 2);

    // Test 3: frame lock with a mid-frame gap on requester 2
    @(posedge clk_25mhz);
    push_src(2, 8'h10, 1'b0, 0);
    push_src(2, 8'h11, 1'b0, 20);
    push_src(2, 8'h12, 1'b1, 0);
    push_src(0, 8'h30, 1'b1, 0);
    expect_byte(2, 8'h10); expect_byte(2, 8'h11);
    expect_byte(2, 8'h12); expect_byte(0, 8'h30);
    t = 0;
    while (t < 100 && src_q[2].size() != 2) begin
      @(negedge clk_25mhz);
      #3;
      t++;
    end
    check("t3_first_accept_seen", (t < 100), 1);
    repeat (15) @(negedge clk_25mhz);
    #3;
    check("t3_gap_lock", {bus.grant_id, bus.active, bus.req_ready}, {2'd2, 1'b1, 4'b0000});
    check("t3_gap_state", dbg.state, ST_IDLE);
    wait_drain("frame_lock", 400);
    check("t3_ptr", dbg.ptr, 1);

    // Test 4: serializer never acknowledges
    model_en = 1'b0;
    @(posedge clk_25mhz);
    push_src(3, 8'h55, 1'b1, 0);
    expect_byte(3, 8'h55);
    t = 0;
    while (t < 100 && err_cnt == 0) begin
      @(negedge clk_25mhz);
      #3;
      t++;
    end
    check("t4_timeout_seen", err_cnt, 1);
    check("t4_ptr_after_timeout", dbg.ptr, 0);
    @(negedge clk_25mhz);
    #3;
    check("t4_err_one_cycle", bus.err_timeout, 0);
    model_en = 1'b1;
    @(posedge clk_25mhz);
    push_src(0, 8'h77, 1'b1, 0);
    push_src(2, 8'h88, 1'b1, 0);
    expect_byte(0, 8'h77);
    expect_byte(2, 8'h88);
    wait_drain("after_timeout", 400);
    check("t4_single_timeout", err_cnt, 1);
    check("t4_ptr", dbg.ptr, 3);

    // Test 5: reset during the drain of byte 2 of a 4-byte frame
    @(posedge clk_25mhz);
    push_src(2, 8'hA0, 1'b0, 0);
    push_src(2, 8'hA1, 1'b0, 0);
    push_src(2, 8'hA2, 1'b0, 0);
    push_src(2, 8'hA3, 1'b1, 0);
    expect_byte(2, 8'hA0);
    expect_byte(2, 8'hA1);
    t = 0;
    while (t < 200 && !(src_q[2].size() == 2 && dbg.state == ST_DRAIN)) begin
      @(negedge clk_25mhz);
      #3;
      t++;
    end
    check("t5_reached_drain", (t < 200), 1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midframe");
    src_q[2].delete();
    repeat (2) @(negedge clk_25mhz);
    #1;
    check("t5_ready_held_in_reset", bus.req_ready, 0);
    resetn = 1'b1;
    @(posedge clk_25mhz);
    push_src(3, 8'hC3, 1'b1, 0);
    push_src(0, 8'hC0, 1'b1, 0);
    expect_byte(0, 8'hC0);
    expect_byte(3, 8'hC3);
    wait_drain("after_reset", 400);
    check("t5_ptr", dbg.ptr, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
